// File: rtl/arb_pkg.sv
// Shared types and default configuration for the round-robin hold arbiter.
//   arb_state_t  : arbiter FSM state encoding (IDLE / GRANT / RELEASE)
//   N_REQ_DEF    : default number of requesters
//   MAX_HOLD_DEF : default hold limit (only used when ARB_HOLD_LIMIT_EN is defined)
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int unsigned N_REQ_DEF    = 3;
  localparam int unsigned MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Scans req starting one position above last_id, wrapping around, and
// returns the first set bit. The previous owner is therefore checked last.
//   req       : request levels, one bit per requester
//   last_id   : index of the most recent owner
//   winner    : one-hot of the selected requester (zero if none)
//   winner_id : index of the selected requester (zero if none)
//   any       : high when at least one request is set
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [N_REQ-1:0] winner,
  output logic [ID_W-1:0]  winner_id,
  output logic             any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    winner    = '0;
    winner_id = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((32'(last_id) + i) % N_REQ);
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner[idx] = 1'b1;
        winner_id   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold and a mandatory dead cycle on handover.
// The owner keeps the grant while it keeps requesting; each release is
// followed by one cycle with no grant before the next winner is granted.
//
// Optional feature (macro ARB_HOLD_LIMIT_EN): an owner that has held the
// grant for MAX_HOLD cycles is forced to release when another requester
// is waiting; preempt pulses in the first dead cycle after such a release.
// Without the macro there is no hold counter and preempt is tied low.
//
// Ports:
//   clk     : clock, all logic on posedge
//   resetn  : synchronous active-low reset
//   req     : per-requester request level
//   gnt     : registered one-hot grant, zero when no owner
//   gnt_vld : high when any gnt bit is set
//   gnt_id  : index of current owner; keeps last owner while gnt_vld is low
//   preempt : one-cycle pulse in the first RELEASE cycle after a forced release
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned ID_W     = $clog2(N_REQ),
  parameter int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [ID_W-1:0]  gnt_id,
  output logic             preempt
);

  arb_state_t       state, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [ID_W-1:0]  gnt_id_d;
  logic [ID_W-1:0]  last_id, last_id_d;
  logic [N_REQ-1:0] winner;
  logic [ID_W-1:0]  winner_id;
  logic             any;

`ifdef ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              preempt_d;
  logic              force_rel;

  // >= rather than == so a saturated owner is preempted as soon as a
  // competitor shows up; gnt masks out the owner's own request.
  assign force_rel = (hold_cnt >= HOLD_W'(MAX_HOLD - 1)) && |(req & ~gnt);
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req       (req),
    .last_id   (last_id),
    .winner    (winner),
    .winner_id (winner_id),
    .any       (any)
  );

  assign gnt_vld = |gnt;

  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    last_id_d = last_id;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d    = hold_cnt;
    preempt_d = 1'b0;
`endif
    case (state)
      IDLE, RELEASE: begin
        if (any) begin
          state_d   = GRANT;
          gnt_d     = winner;
          gnt_id_d  = winner_id;
          last_id_d = winner_id;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d    = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (force_rel) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          preempt_d = 1'b1;
        end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      last_id <= ID_W'(N_REQ - 1);
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      last_id <= last_id_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      hold_cnt <= hold_d;
      preempt  <= preempt_d;
    end
  end
`else
  assign preempt = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_HOLD), 32'(HOLD_W)};
`endif

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter (N_REQ=3, MAX_HOLD=4).
// The driver applies one input vector per cycle and queues the outputs
// expected after that edge; the monitor pops and compares on each negedge.
module tb_rr_hold_arbiter;

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] id;
    logic       pre;
    string      name;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       preempt;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  rr_hold_arbiter #(
    .N_REQ    (3),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic [2:0] r, input logic [2:0] eg,
                      input logic [1:0] eid, input logic ep, input string nm);
    exp_t e;
    resetn = rn;
    req    = r;
    @(posedge clk);
    e.gnt  = eg;
    e.id   = eid;
    e.pre  = ep;
    e.name = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (gnt !== e.gnt || gnt_vld !== (|e.gnt) || gnt_id !== e.id || preempt !== e.pre) begin
          n_fail++;
          $display("FAIL %s @%0t: gnt=%b gnt_vld=%b gnt_id=%0d preempt=%b, expected gnt=%b gnt_vld=%b gnt_id=%0d preempt=%b",
                   e.name, $time, gnt, gnt_vld, gnt_id, preempt, e.gnt, |e.gnt, e.id, e.pre);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    logic [2:0] eg;
    logic [1:0] eid;
    logic       ep;
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    req      = 3'b000;

    // 1: reset with all requests, then requester 0 wins first
    for (int i = 0; i < 3; i++) step(1'b0, 3'b111, 3'b000, 2'd0, 1'b0, "reset");
    step(1'b1, 3'b111, 3'b001, 2'd0, 1'b0, "first_after_reset");
    step(1'b1, 3'b000, 3'b000, 2'd0, 1'b0, "release0");
    step(1'b1, 3'b000, 3'b000, 2'd0, 1'b0, "idle0");

    // 2: single requester, held then dropped
    step(1'b1, 3'b010, 3'b010, 2'd1, 1'b0, "single_grant");
    for (int i = 0; i < 3; i++) step(1'b1, 3'b010, 3'b010, 2'd1, 1'b0, "single_hold");
    step(1'b1, 3'b000, 3'b000, 2'd1, 1'b0, "single_release");
    step(1'b1, 3'b000, 3'b000, 2'd1, 1'b0, "single_idle");

    // 3: rotation 0,1,2,0 with one dead cycle between grants
    step(1'b0, 3'b000, 3'b000, 2'd0, 1'b0, "rot_reset");
    step(1'b1, 3'b111, 3'b001, 2'd0, 1'b0, "rot_g0a");
    step(1'b1, 3'b111, 3'b001, 2'd0, 1'b0, "rot_g0b");
    step(1'b1, 3'b110, 3'b000, 2'd0, 1'b0, "rot_dead0");
    step(1'b1, 3'b111, 3'b010, 2'd1, 1'b0, "rot_g1a");
    step(1'b1, 3'b111, 3'b010, 2'd1, 1'b0, "rot_g1b");
    step(1'b1, 3'b101, 3'b000, 2'd1, 1'b0, "rot_dead1");
    step(1'b1, 3'b111, 3'b100, 2'd2, 1'b0, "rot_g2a");
    step(1'b1, 3'b111, 3'b100, 2'd2, 1'b0, "rot_g2b");
    step(1'b1, 3'b011, 3'b000, 2'd2, 1'b0, "rot_dead2");
    step(1'b1, 3'b111, 3'b001, 2'd0, 1'b0, "rot_g0_again");
    step(1'b1, 3'b000, 3'b000, 2'd0, 1'b0, "rot_release");
    step(1'b1, 3'b000, 3'b000, 2'd0, 1'b0, "rot_idle");

    // 4: two contenders held continuously
    step(1'b0, 3'b000, 3'b000, 2'd0, 1'b0, "pre_reset");
    for (int i = 1; i <= 12; i++) begin
`ifdef ARB_HOLD_LIMIT_EN
      if (i <= 4)       begin eg = 3'b001; eid = 2'd0; ep = 1'b0; end
      else if (i == 5)  begin eg = 3'b000; eid = 2'd0; ep = 1'b1; end
      else if (i <= 9)  begin eg = 3'b010; eid = 2'd1; ep = 1'b0; end
      else if (i == 10) begin eg = 3'b000; eid = 2'd1; ep = 1'b1; end
      else              begin eg = 3'b001; eid = 2'd0; ep = 1'b0; end
`else
      eg = 3'b001; eid = 2'd0; ep = 1'b0;
`endif
      step(1'b1, 3'b011, eg, eid, ep, "hold_limit");
    end
    step(1'b1, 3'b000, 3'b000, 2'd0, 1'b0, "hold_release");
    step(1'b1, 3'b000, 3'b000, 2'd0, 1'b0, "hold_idle");

    // 5: sole holder saturates, preempted once a competitor appears
    for (int i = 0; i < 10; i++) step(1'b1, 3'b001, 3'b001, 2'd0, 1'b0, "sole_hold");
`ifdef ARB_HOLD_LIMIT_EN
    step(1'b1, 3'b101, 3'b000, 2'd0, 1'b1, "sole_preempt");
    step(1'b1, 3'b101, 3'b100, 2'd2, 1'b0, "sole_next");
`else
    step(1'b1, 3'b101, 3'b001, 2'd0, 1'b0, "sole_preempt");
    step(1'b1, 3'b101, 3'b001, 2'd0, 1'b0, "sole_next");
`endif

    // 6: reset while requester 2 owns the grant
    step(1'b0, 3'b000, 3'b000, 2'd0, 1'b0, "mid_pre_reset");
    step(1'b1, 3'b100, 3'b100, 2'd2, 1'b0, "mid_g2a");
    step(1'b1, 3'b100, 3'b100, 2'd2, 1'b0, "mid_g2b");
    step(1'b0, 3'b100, 3'b000, 2'd0, 1'b0, "mid_reset");
    step(1'b1, 3'b111, 3'b001, 2'd0, 1'b0, "mid_after_reset");

    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
